mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_BURST, default 4: consecutive data grants allowed while an instruction request waits (range 1..15).
REQ-002 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, asynchronous active-low reset); all state SHALL sample on the rising edge of clk.
REQ-003 i_req  in  1  instruction-side request; i_addr  in  32  fetch address.
REQ-004 i_rdata  out  32  fetched word; i_ack_n  out  1  instruction completion, active-low.
REQ-005 d_req  in  1  data request (core MREQ); d_write  in  1  1 = store; d_size  in  2  access size; d_addr  in  32; d_wdata  in  32.
REQ-006 d_rdata  out  32  load data; d_ack_n  out  1  data completion, active-low.
REQ-007 m_req  out  1; m_write  out  1; m_size  out  2; m_addr  out  32; m_wdata  out  32: unified memory port.
REQ-008 m_rdata  in  32; m_ack_n  in  1  memory completion, active-low.

Function
REQ-009 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-010 A grant decision SHALL be made in IDLE, or in a GNT state on the completion cycle (m_ack_n=0), from i_req and d_req sampled that cycle.
REQ-011 Decision: d_req only -> GNT_D; i_req only -> GNT_I; neither -> IDLE.
REQ-012 Both requests pending: GNT_D if streak < MAX_D_BURST, else GNT_I.
REQ-013 On entering a GNT state, the winner's address, size, write and wdata SHALL be latched into m_* registers; instruction grants SHALL force m_write=0 and m_size=2'b10.
REQ-014 m_req SHALL be 1 in GNT_I/GNT_D and 0 in IDLE; latched m_* fields SHALL hold until completion, regardless of requester input changes.
REQ-015 Completion in GNT_I with m_ack_n=0 SHALL drive i_ack_n=0 combinationally that cycle, with i_rdata=m_rdata; GNT_D SHALL do the same on d_ack_n/d_rdata.
REQ-016 i_ack_n and d_ack_n SHALL be 1 in all other cycles; the two SHALL never be 0 together.
REQ-017 Minimum latency: request sampled in IDLE -> m_req=1 the next cycle -> ack in the first cycle m_ack_n=0; no upper bound (the memory controls waits).
REQ-018 Back-to-back: completion cycle SHALL transition directly to the next GNT state without an IDLE bubble.
REQ-019 A requester still asserting req on its own ack cycle SHALL be treated as a new request.
REQ-020 Streak counter (4 bits): +1 on each data completion while i_req=1; cleared on each instruction completion and on any data completion with i_req=0.
REQ-021 The streak counter SHALL saturate at MAX_D_BURST and never wrap.
REQ-022 i_rdata/d_rdata SHALL equal m_rdata continuously; requesters qualify the data with their ack only.
REQ-023 A request deasserted before grant SHALL be dropped silently; a request deasserted after grant SHALL NOT abort the memory transaction.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE; m_req=0; m_write=0; m_size=0; m_addr=0; m_wdata=0; streak=0; i_ack_n=1; d_ack_n=1.
REQ-025 Reset asserted mid-transaction SHALL abandon it with no ack issued; after deassertion the first decision SHALL occur in IDLE.

Structure
REQ-026 FSM state encoding and size codes (byte 00, half 01, word 10) SHALL live in the shared core defines package.
REQ-027 The streak counter SHALL be one sub-module, arb_streak_cnt (inputs inc, clr; output sat flag).
REQ-028 Target size SHALL be 120-400 RTL lines; no other sub-modules.

Verification
REQ-029 i_req=1, i_addr=0x0000_0100, m_ack_n=0 immediately -> m_req=1, m_addr=0x100, m_write=0 next cycle; i_ack_n=0 that same cycle.
REQ-030 Both requests pending, d_write=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> GNT_D first with m_wdata=0xDEADBEEF; then GNT_I follows with no IDLE cycle.
REQ-031 d_req held high and i_req high, MAX_D_BURST=4, m_ack_n=0 every cycle -> grant sequence D,D,D,D,I,D,D,D,D,I.
REQ-032 GNT_D with m_ack_n=1 for 5 cycles while d_addr changes to 0x3000 -> m_addr stays 0x2000; d_ack_n=0 only in cycle 6.
REQ-033 rst_n=0 during GNT_I -> m_req=0 and i_ack_n=1 asynchronously; after release with no requests -> state remains IDLE.
REQ-034 Random bench -> i_ack_n and d_ack_n never both 0; each ack is preceded by a matching grant.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared defines for the instruction/data memory bus arbiter.
// FSM state encoding, access size codes and the latched command bundle.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the bus arbiter.
// master: the arbiter's view; slave: the surrounding core/memory.
interface mem_bus_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack_n;

    logic        d_req;
    logic        d_write;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack_n;

    logic        m_req;
    logic        m_write;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack_n;

    modport master (
        input  i_req, i_addr,
        output i_rdata, i_ack_n,
        input  d_req, d_write, d_size, d_addr, d_wdata,
        output d_rdata, d_ack_n,
        output m_req, m_write, m_size, m_addr, m_wdata,
        input  m_rdata, m_ack_n
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_ack_n,
        output d_req, d_write, d_size, d_addr, d_wdata,
        input  d_rdata, d_ack_n,
        input  m_req, m_write, m_size, m_addr, m_wdata,
        output m_rdata, m_ack_n
    );

endinterface

// File: rtl/arb_streak_cnt.sv
// Saturating count of back-to-back data grants taken while a fetch waits.
// sat reflects the count after this cycle's update, so it steers the grant made now.
module arb_streak_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [3:0] LIM = 4'(MAX);

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    // clear wins over increment; increment stops at the limit
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && (cnt < LIM)) begin
            cnt_nxt = cnt + 4'd1;
        end
    end

    assign sat = (cnt_nxt >= LIM);

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction fetch and data access onto one memory port.
// Data wins ties until MAX_D_BURST grants in a row, then the fetch gets a turn.
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_arbiter_if.master bus
);

    arb_state_e state;
    arb_state_e state_nxt;
    mem_cmd_t   cmd_q;
    mem_cmd_t   cmd_nxt;

    logic done;
    logic i_done;
    logic d_done;
    logic decide;
    logic streak_inc;
    logic streak_clr;
    logic sat;

    assign done   = !bus.m_ack_n;
    assign i_done = (state == ST_GNT_I) && done;
    assign d_done = (state == ST_GNT_D) && done;
    assign decide = (state == ST_IDLE) || done;

    assign streak_inc = d_done && bus.i_req;
    assign streak_clr = i_done || (d_done && !bus.i_req);

    arb_streak_cnt #(
        .MAX (MAX_D_BURST)
    ) u_streak (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (streak_inc),
        .clr   (streak_clr),
        .sat   (sat)
    );

    // grant decision and capture of the winner's command
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        if (decide) begin
            unique case (1'b1)
                (bus.d_req && !(bus.i_req && sat)): begin
                    state_nxt     = ST_GNT_D;
                    cmd_nxt.write = bus.d_write;
                    cmd_nxt.size  = bus.d_size;
                    cmd_nxt.addr  = bus.d_addr;
                    cmd_nxt.wdata = bus.d_wdata;
                end
                (bus.i_req && !(bus.d_req && !sat)): begin
                    state_nxt     = ST_GNT_I;
                    cmd_nxt.write = 1'b0;
                    cmd_nxt.size  = SZ_WORD;
                    cmd_nxt.addr  = bus.i_addr;
                    cmd_nxt.wdata = '0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // latched memory command, held until the transfer completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_nxt;
        end
    end

    assign bus.m_req   = (state != ST_IDLE);
    assign bus.m_write = cmd_q.write;
    assign bus.m_size  = cmd_q.size;
    assign bus.m_addr  = cmd_q.addr;
    assign bus.m_wdata = cmd_q.wdata;

    assign bus.i_ack_n = !i_done;
    assign bus.d_ack_n = !d_done;
    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;

endmodule
